// File: rtl/sweep_seq.sv
// sweep_seq: steps the stimulus DDS through indices 0..IDX_MAX, settling and capturing one FFT per point.
// Optional build macro SWEEP_REPEAT_EN: wrap back to index 0 after the last point and sweep until abort.
module sweep_seq #(
    parameter int unsigned IDX_MAX     = 2751,
    parameter int unsigned IDX_STEP    = 1,
    parameter int unsigned SETTLE_CYC  = 149997,
    parameter int unsigned FFT_TIMEOUT = 200000,
    parameter int unsigned DDS_K       = 26844
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        fft_done,
    output logic [15:0] freq_idx,
    output logic [31:0] dds_word,
    output logic        dds_load,
    output logic        fft_start,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [11:0] miss_cnt
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > FFT_TIMEOUT) ? SETTLE_CYC : FFT_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FFT_TIMEOUT - 1);
    localparam logic [16:0]      STEP_W       = 17'(IDX_STEP);
    localparam logic [16:0]      MAX_W        = 17'(IDX_MAX);
    localparam logic [31:0]      DDS_K_W      = 32'(DDS_K);

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        LOAD    = 5'b00010,
        SETTLE  = 5'b00100,
        CAPTURE = 5'b01000,
        NEXT    = 5'b10000
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      freq_idx_q, freq_idx_d;
    logic [31:0]      dds_word_q, dds_word_d;
    logic             dds_load_q, dds_load_d;
    logic             fft_start_q, fft_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_err_q, timeout_err_d;
    logic [11:0]      miss_cnt_q, miss_cnt_d;

    logic [16:0] idx_sum;
    logic        last_point;
    logic        settle_end;
    logic        timeout_end;

    // 17-bit sum so an index near the top of the 16-bit range cannot wrap past IDX_MAX.
    assign idx_sum     = {1'b0, freq_idx_q} + STEP_W;
    assign last_point  = idx_sum > MAX_W;
    assign settle_end  = cnt_q == SETTLE_LAST;
    assign timeout_end = cnt_q == TIMEOUT_LAST;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            freq_idx_q    <= '0;
            dds_word_q    <= '0;
            dds_load_q    <= 1'b0;
            fft_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            freq_idx_q    <= freq_idx_d;
            dds_word_q    <= dds_word_d;
            dds_load_q    <= dds_load_d;
            fft_start_q   <= fft_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = LOAD;
            LOAD:    state_d = SETTLE;
            SETTLE:  if (settle_end) state_d = CAPTURE;
            CAPTURE: if (fft_done || timeout_end) state_d = NEXT;
`ifdef SWEEP_REPEAT_EN
            NEXT:    state_d = LOAD;
`else
            NEXT:    state_d = last_point ? IDLE : LOAD;
`endif
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d         = '0;
        freq_idx_d    = freq_idx_q;
        dds_word_d    = dds_word_q;
        timeout_err_d = timeout_err_q;
        miss_cnt_d    = miss_cnt_q;
        done_d        = 1'b0;

        if (state_d == state_q && (state_q == SETTLE || state_q == CAPTURE))
            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: if (state_d == LOAD) begin
                freq_idx_d    = '0;
                timeout_err_d = 1'b0;
                miss_cnt_d    = '0;
            end
            CAPTURE: if (state_d == NEXT && !fft_done) begin
                timeout_err_d = 1'b1;
                if (miss_cnt_q != 12'hfff) miss_cnt_d = miss_cnt_q + 12'd1;
            end
            NEXT: if (state_d == LOAD) begin
`ifdef SWEEP_REPEAT_EN
                if (last_point) begin
                    freq_idx_d = '0;
                    miss_cnt_d = '0;
                    done_d     = 1'b1;
                end else begin
                    freq_idx_d = idx_sum[15:0];
                end
`else
                freq_idx_d = idx_sum[15:0];
`endif
            end else if (state_d == IDLE && !abort) begin
                done_d = 1'b1;
            end
            default: ;
        endcase

        // The word is registered on entry to LOAD so it is stable while dds_load is high.
        if (state_d == LOAD) dds_word_d = 32'(freq_idx_d) * DDS_K_W;

        dds_load_d  = state_d == LOAD;
        fft_start_d = (state_d == CAPTURE) && (state_q != CAPTURE);
        busy_d      = state_d != IDLE;
    end

    assign freq_idx    = freq_idx_q;
    assign dds_word    = dds_word_q;
    assign dds_load    = dds_load_q;
    assign fft_start   = fft_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_sweep_seq.sv
// Bench for sweep_seq: each scenario is turned into an event schedule (load, fft_start, capture end,
// done) from the latency rules, then every cycle of the DUT is compared against that schedule.
module tb_sweep_seq;

    localparam int IDX_MAX     = 3;
    localparam int IDX_STEP    = 1;
    localparam int SETTLE_CYC  = 4;
    localparam int FFT_TIMEOUT = 20;
    localparam int DDS_K       = 10;
    localparam int MAXP        = 8;
    localparam int NEVER       = 1000000;
    localparam int WITHHELD    = 1000;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fft_done = 1'b0;
    logic [15:0] freq_idx;
    logic [31:0] dds_word;
    logic        dds_load;
    logic        fft_start;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [11:0] miss_cnt;
    logic [64:0] all_out;

    int vectors = 0;
    int miscompares = 0;
    int dly_cfg[MAXP];

    always #5 clk_50m = ~clk_50m;

    sweep_seq #(
        .IDX_MAX(IDX_MAX), .IDX_STEP(IDX_STEP), .SETTLE_CYC(SETTLE_CYC),
        .FFT_TIMEOUT(FFT_TIMEOUT), .DDS_K(DDS_K)
    ) dut (
        .clk_50m(clk_50m), .rst(rst), .start(start), .abort(abort), .fft_done(fft_done),
        .freq_idx(freq_idx), .dds_word(dds_word), .dds_load(dds_load), .fft_start(fft_start),
        .busy(busy), .done(done), .timeout_err(timeout_err), .miss_cnt(miss_cnt)
    );

    assign all_out = {freq_idx, dds_word, dds_load, fft_start, busy, done, timeout_err, miss_cnt};

    // One sweep: start in cycle 1, optional abort at (point, offset from its load), optional noise.
    task automatic run_scn(input string name, input int abort_pt, input int abort_off, input bit noise);
        int l_c[MAXP], f_c[MAXP], e_c[MAXP], idx_p[MAXP];
        bit to_p[MAXP], wrap_p[MAXP];
        int np, t, idx, a_c, end_c, stop_c, cc, wrap_c;
        bit e_load, e_fstart, e_done, e_busy, e_terr;
        int e_idx, e_miss;
        bit is_last;

        np = 0; t = 2; idx = 0; end_c = NEVER;
        while (np < MAXP) begin
            l_c[np] = t;
            f_c[np] = t + SETTLE_CYC + 1;
            if (dly_cfg[np] < FFT_TIMEOUT) begin
                e_c[np] = f_c[np] + dly_cfg[np];
                to_p[np] = 1'b0;
            end else begin
                e_c[np] = f_c[np] + FFT_TIMEOUT - 1;
                to_p[np] = 1'b1;
            end
            idx_p[np] = idx;
            is_last = (idx + IDX_STEP) > IDX_MAX;
            wrap_p[np] = is_last;
            t = e_c[np] + 2;
            np++;
            if (is_last) begin
`ifdef SWEEP_REPEAT_EN
                idx = 0;
`else
                end_c = t;
                break;
`endif
            end else begin
                idx += IDX_STEP;
            end
        end

        if (abort_pt >= 0) a_c = l_c[abort_pt] + abort_off;
`ifdef SWEEP_REPEAT_EN
        else a_c = e_c[np-1] + 1;
`else
        else a_c = NEVER;
`endif
        stop_c = ((end_c < a_c + 1) ? end_c : a_c + 1) + 4;

        @(posedge clk_50m);
        for (int c = 0; c <= stop_c; c++) begin
            @(negedge clk_50m);
            if (c >= 2) begin
                cc = (c < a_c) ? c : a_c;
                e_load = 0; e_fstart = 0; e_done = 0; e_terr = 0; e_idx = 0; e_miss = 0; wrap_c = 0;
                for (int p = 0; p < np; p++) begin
                    if (l_c[p] == c) e_load = 1;
                    if (f_c[p] == c) e_fstart = 1;
                    if (wrap_p[p] && e_c[p] + 2 == c) e_done = 1;
                    if (l_c[p] <= cc) e_idx = idx_p[p];
                    if (to_p[p] && e_c[p] + 1 <= cc) e_terr = 1;
`ifdef SWEEP_REPEAT_EN
                    if (wrap_p[p] && e_c[p] + 2 <= cc) wrap_c = e_c[p] + 2;
`endif
                end
                for (int p = 0; p < np; p++)
                    if (to_p[p] && e_c[p] + 1 <= cc && e_c[p] + 1 > wrap_c) e_miss++;
                if (c > a_c) begin
                    e_load = 0; e_fstart = 0; e_done = 0;
                end
                e_busy = (c <= a_c) && (c < end_c);

                vectors++;
                if ({dds_load, fft_start, done, busy, timeout_err} !== {e_load, e_fstart, e_done, e_busy, e_terr}
                    || freq_idx !== 16'(e_idx) || dds_word !== 32'(e_idx * DDS_K) || miss_cnt !== 12'(e_miss)) begin
                    miscompares++;
                    $display("FAIL %s cyc %0d: got load/fstart/done/busy/terr=%b%b%b%b%b idx=%0d word=%0d miss=%0d, expected %b%b%b%b%b idx=%0d word=%0d miss=%0d",
                             name, c, dds_load, fft_start, done, busy, timeout_err, freq_idx, dds_word, miss_cnt,
                             e_load, e_fstart, e_done, e_busy, e_terr, e_idx, e_idx * DDS_K, e_miss);
                end
            end

            start = (c == 1) || (noise && c >= 2 && c <= a_c && c < end_c && $urandom_range(0, 5) == 0);
            abort = (c == a_c);
            fft_done = 1'b0;
            for (int p = 0; p < np; p++) begin
                if (!to_p[p] && e_c[p] == c) fft_done = 1'b1;
                if (to_p[p] && dly_cfg[p] != WITHHELD && f_c[p] + dly_cfg[p] == c) fft_done = 1'b1;
                if (noise && c > l_c[p] && c < f_c[p] && $urandom_range(0, 2) == 0) fft_done = 1'b1;
            end
        end
        start = 1'b0; abort = 1'b0; fft_done = 1'b0;
    endtask

    function automatic int rand_dly();
        case ($urandom_range(0, 9))
            6:       return FFT_TIMEOUT - 1;
            7:       return WITHHELD;
            8:       return FFT_TIMEOUT + int'($urandom_range(0, 4));
            9:       return int'($urandom_range(0, FFT_TIMEOUT - 1));
            default: return int'($urandom_range(0, 6));
        endcase
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk_50m);
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset: outputs=%h expected 0", all_out);
        end
        rst = 1'b0;
        @(negedge clk_50m);
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_release: outputs=%h expected 0", all_out);
        end
    endtask

    task automatic test_basic_sweep();
        for (int p = 0; p < MAXP; p++) dly_cfg[p] = 3;
        run_scn("basic", -1, 0, 1'b0);
    endtask

    task automatic test_timeout_point();
        for (int p = 0; p < MAXP; p++) dly_cfg[p] = 3;
        dly_cfg[2] = WITHHELD;
        run_scn("timeout_point", -1, 0, 1'b0);
    endtask

    task automatic test_abort_settle();
        for (int p = 0; p < MAXP; p++) dly_cfg[p] = 3;
        dly_cfg[0] = WITHHELD;
        run_scn("abort_settle", 1, 2, 1'b0);
        dly_cfg[0] = 3;
        run_scn("restart", -1, 0, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        for (int p = 0; p < MAXP; p++) dly_cfg[p] = int'($urandom_range(0, 6));
        run_scn("ignored_inputs", -1, 0, 1'b1);
    endtask

    task automatic test_timeout_edge();
        for (int p = 0; p < MAXP; p++) dly_cfg[p] = 2;
        dly_cfg[0] = FFT_TIMEOUT - 1;
        dly_cfg[1] = 0;
        dly_cfg[2] = FFT_TIMEOUT - 1;
        dly_cfg[3] = FFT_TIMEOUT;
        run_scn("timeout_edge", -1, 0, 1'b0);
    endtask

    task automatic test_idle_conflict();
        @(negedge clk_50m);
        start = 1'b1; abort = 1'b1;
        @(negedge clk_50m);
        start = 1'b0; abort = 1'b0;
        repeat (3) begin
            vectors++;
            if (busy !== 1'b0 || dds_load !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_conflict: busy=%b dds_load=%b expected 0 0", busy, dds_load);
            end
            @(negedge clk_50m);
        end
    endtask

    task automatic test_random();
        int a_pt, a_off;
        for (int n = 0; n < 12; n++) begin
            for (int p = 0; p < MAXP; p++) dly_cfg[p] = rand_dly();
            a_pt = -1; a_off = 0;
            if ($urandom_range(0, 2) == 0) begin
                a_pt  = int'($urandom_range(0, 3));
                a_off = int'($urandom_range(0, 6));
            end
            run_scn($sformatf("random%0d", n), a_pt, a_off, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back_reset();
        @(negedge clk_50m);
        start = 1'b1;
        @(negedge clk_50m);
        start = 1'b0;
        repeat (SETTLE_CYC + 1) @(negedge clk_50m);
        fft_done = 1'b1;
        @(negedge clk_50m);
        fft_done = 1'b0;
        repeat (SETTLE_CYC + 2) @(negedge clk_50m);
        vectors++;
        if (fft_start !== 1'b1 || busy !== 1'b1 || freq_idx !== 16'd1 || dds_word !== 32'(DDS_K)) begin
            miscompares++;
            $display("FAIL pre_reset: fft_start=%b busy=%b idx=%0d word=%0d expected 1 1 1 %0d",
                     fft_start, busy, freq_idx, dds_word, DDS_K);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL async_reset: outputs=%h expected 0", all_out);
        end
        @(negedge clk_50m);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk_50m);
            vectors++;
            if (all_out !== '0) begin
                miscompares++;
                $display("FAIL post_reset_idle: outputs=%h expected 0", all_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_timeout_point();
        test_abort_settle();
        test_ignored_inputs();
        test_timeout_edge();
        test_idle_conflict();
        test_random();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
